clk_div_ratio_ctrl: RTL
=======================

Name: clk_div_ratio_ctrl

Overview:
- Control stage directly upstream of the integer clock divider. It drives the divider's ratio and clock-enable inputs.
- Converts a UART prescale configuration (4/8/16/32) into a divide ratio (8/4/2/1).
- Applies a ratio change only at a divided-clock period boundary, with a short enable-low settle window, so the divider never sees a mid-period ratio change.
- Runs entirely in the i_ref_clk domain, alongside the divider.

Parameters:
- PRESCALE_WIDTH, 6, width of prescale config input
- RATIO_WIDTH, 8, width of o_div_ratio (matches divider ratio input)
- DEFAULT_RATIO, 1, o_div_ratio value after reset
- SETTLE_CYCLES, 2, i_ref_clk cycles o_clk_en is held low during a ratio switch (legal range 1..15)

Ports:
- i_ref_clk  in  1  reference clock; also the divider's source clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_ctrl_en  in  1  system enable for the divided clock (level)
- i_prescale  in  PRESCALE_WIDTH  requested prescale
- i_prescale_vld  in  1  request valid
- o_prescale_rdy  out  1  request can be accepted
- o_div_ratio  out  RATIO_WIDTH  ratio to divider; registered
- o_clk_en  out  1  divider enable; registered
- o_busy  out  1  a ratio switch is in progress
- o_cfg_err  out  1  one-cycle pulse: unsupported prescale rejected

Behaviour:
- Reset values:
  - state=IDLE, o_div_ratio=DEFAULT_RATIO, o_clk_en=0, o_busy=0, o_cfg_err=0
  - period counter=0, pending ratio=DEFAULT_RATIO
  - o_prescale_rdy=1 (decoded from state)
- Mapping: prescale 32->1, 16->2, 8->4, 4->8. Any other value, including 0, is unsupported.
- Handshake:
  - A request is accepted on a cycle with i_prescale_vld && o_prescale_rdy.
  - o_prescale_rdy=1 only in IDLE and RUN.
  - An unsupported value is still accepted: o_cfg_err pulses the next cycle, with no ratio or state change.
- Period counter:
  - Active only while o_clk_en=1; forced to 0 whenever o_clk_en=0.
  - Counts 0..cur_ratio-1 and wraps.
  - Boundary = (cnt==cur_ratio-1). For ratio 1 every cycle is a boundary.
  - This mirrors the divider, whose output restarts high when it is re-enabled.
- States:
  - IDLE: o_clk_en=0.
    - Supported request: o_div_ratio updated next cycle; no gating.
    - i_ctrl_en=1: go to RUN; o_clk_en=1 next cycle; cnt=0.
  - RUN: o_clk_en=1.
    - Supported request equal to cur ratio: accepted, no effect.
    - Supported request with a different ratio: latch it into pending and go to PEND; o_busy=1 next cycle.
  - PEND: wait for boundary. On the boundary cycle go to GATE: o_clk_en<=0, o_div_ratio<=pending.
  - GATE: hold o_clk_en=0 for exactly SETTLE_CYCLES cycles, then go to RUN: o_clk_en<=1, cnt<=0, o_busy<=0.
- Worst-case switch latency from accept to o_clk_en high: 1 + cur_ratio + SETTLE_CYCLES cycles.
- i_ctrl_en=0 in any state:
  - Go to IDLE next cycle with o_clk_en=0 and o_busy=0.
  - A pending ratio is committed to o_div_ratio immediately.
- Simultaneous events:
  - i_ctrl_en falling and a request in the same cycle: the request is processed as in IDLE.
  - i_ctrl_en rising in IDLE together with a supported request: the new ratio and o_clk_en=1 both appear next cycle; cnt starts at 0 against the new ratio.
- Reset asserted mid-switch: all registers return to reset values immediately (asynchronous).

Optional Feature:
- Macro: CLK_DIV_RATIO_CTRL_STATS_EN.
- Defined:
  - Adds output o_switch_cnt[7:0], which increments on each GATE->RUN transition and saturates at 255. Reset to 0 only by i_rst_n.
  - Adds output o_err_sticky, which is set by o_cfg_err and cleared only by reset.
- Undefined: neither port nor its logic exists. All other behaviour is identical.

Decomposition:
- Shared package clk_div_pkg holds:
  - state encodings IDLE/RUN/PEND/GATE (2-bit)
  - prescale constants 4/8/16/32 and their ratio constants 8/4/2/1
  - the prescale-to-ratio function
  - the SETTLE_CYCLES default
- Sub-module clk_div_period_cnt (inputs: enable, ratio; output: boundary flag) is the natural split. The FSM and handshake remain in the top.

Test Plan:
- Reset, then i_ctrl_en=1 -> o_clk_en=1 one cycle later, o_div_ratio=1, o_prescale_rdy=1, o_busy=0.
- In IDLE send prescale=8 -> o_div_ratio=4 next cycle; no o_busy; then enable -> o_clk_en rises, cnt wraps every 4 cycles.
- RUN at ratio 4, send prescale=4 when cnt=1 -> o_busy=1; o_clk_en falls at the cnt=3 boundary and o_div_ratio=8 on the same edge; 2 cycles low; o_clk_en=1, o_busy=0.
- Send prescale=12, then prescale=0 -> o_cfg_err pulses 1 cycle each; o_div_ratio and o_clk_en unchanged.
- During PEND (ratio 8->2) drop i_ctrl_en -> IDLE next cycle, o_clk_en=0, o_div_ratio=2, o_busy=0.
- Assert i_rst_n=0 mid-GATE -> all outputs at reset values immediately; release -> IDLE with o_div_ratio=DEFAULT_RATIO.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and constants for the divider ratio control stage.
// Prescale decode and FSM state encodings.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2,
    GATE = 2'd3
  } state_t;

  localparam int PS_4  = 4;
  localparam int PS_8  = 8;
  localparam int PS_16 = 16;
  localparam int PS_32 = 32;

  localparam int RATIO_PS_4  = 8;
  localparam int RATIO_PS_8  = 4;
  localparam int RATIO_PS_16 = 2;
  localparam int RATIO_PS_32 = 1;

  localparam int SETTLE_DEFAULT = 2;

  // zero means unsupported prescale
  function automatic logic [7:0] ps2ratio(
    input logic [31:0] ps
  );
    logic [7:0] r;
    r = 8'd0;
    unique case (1'b1)
      (ps == 32'(PS_4)):  r = 8'(RATIO_PS_4);
      (ps == 32'(PS_8)):  r = 8'(RATIO_PS_8);
      (ps == 32'(PS_16)): r = 8'(RATIO_PS_16);
      (ps == 32'(PS_32)): r = 8'(RATIO_PS_32);
      default:            r = 8'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/clk_div_ratio_ctrl_period_cnt.sv
// Shadow of the divider's period counter; flags the last
// reference cycle of each divided-clock period.
module clk_div_period_cnt
  import clk_div_pkg::*;
#(
  parameter int RATIO_WIDTH = 8
) (
  input  logic                   i_ref_clk,
  input  logic                   i_rst_n,
  input  logic                   en,
  input  logic [RATIO_WIDTH-1:0] ratio,
  output logic                   boundary
);

  logic [RATIO_WIDTH-1:0] cnt;
  logic                   last;

  assign last     = (cnt == ratio - 1'b1);
  assign boundary = en && last;

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (!en || last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/clk_div_ratio_ctrl.sv
// Prescale-to-ratio control for the integer divider, switching
// only at period boundaries. Stats: CLK_DIV_RATIO_CTRL_STATS_EN.
module clk_div_ratio_ctrl
  import clk_div_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 6,
  parameter int RATIO_WIDTH    = 8,
  parameter int DEFAULT_RATIO  = 1,
  parameter int SETTLE_CYCLES  = SETTLE_DEFAULT
) (
  input  logic                      i_ref_clk,
  input  logic                      i_rst_n,
  input  logic                      i_ctrl_en,
  input  logic [PRESCALE_WIDTH-1:0] i_prescale,
  input  logic                      i_prescale_vld,
  output logic                      o_prescale_rdy,
  output logic [RATIO_WIDTH-1:0]    o_div_ratio,
  output logic                      o_clk_en,
  output logic                      o_busy,
`ifdef CLK_DIV_RATIO_CTRL_STATS_EN
  output logic [7:0]                o_switch_cnt,
  output logic                      o_err_sticky,
`endif
  output logic                      o_cfg_err
);

  localparam logic [RATIO_WIDTH-1:0] DEF_R =
    RATIO_WIDTH'(DEFAULT_RATIO);
  localparam logic [3:0] SETTLE_LAST =
    4'(SETTLE_CYCLES - 1);

  state_t                 state, nxt;
  logic [RATIO_WIDTH-1:0] pending, pend_n;
  logic [RATIO_WIDTH-1:0] ratio_n;
  logic [RATIO_WIDTH-1:0] req_ratio;
  logic [3:0]             settle, settle_n;
  logic                   en_n, busy_n, err_n;
  logic                   accept, req_ok, boundary;

  assign o_prescale_rdy = (state == IDLE) ||
                          (state == RUN);
  assign accept    = i_prescale_vld && o_prescale_rdy;
  assign req_ratio = RATIO_WIDTH'(ps2ratio(32'(i_prescale)));
  assign req_ok    = (req_ratio != '0);

  clk_div_period_cnt #(
    .RATIO_WIDTH(RATIO_WIDTH)
  ) u_cnt (
    .i_ref_clk(i_ref_clk),
    .i_rst_n  (i_rst_n),
    .en       (o_clk_en),
    .ratio    (o_div_ratio),
    .boundary (boundary)
  );

  always_comb begin
    nxt      = state;
    ratio_n  = o_div_ratio;
    en_n     = o_clk_en;
    busy_n   = o_busy;
    pend_n   = pending;
    settle_n = settle;
    err_n    = accept && !req_ok;
    if (!i_ctrl_en) begin
      nxt    = IDLE;
      en_n   = 1'b0;
      busy_n = 1'b0;
      if (state == PEND || state == GATE) begin
        ratio_n = pending;
      end
      if (accept && req_ok) begin
        ratio_n = req_ratio;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (accept && req_ok) begin
            ratio_n = req_ratio;
          end
          nxt  = RUN;
          en_n = 1'b1;
        end
        RUN: begin
          if (accept && req_ok &&
              req_ratio != o_div_ratio) begin
            pend_n = req_ratio;
            nxt    = PEND;
            busy_n = 1'b1;
          end
        end
        PEND: begin
          if (boundary) begin
            nxt      = GATE;
            en_n     = 1'b0;
            ratio_n  = pending;
            settle_n = '0;
          end
        end
        GATE: begin
          if (settle == SETTLE_LAST) begin
            nxt    = RUN;
            en_n   = 1'b1;
            busy_n = 1'b0;
          end else begin
            settle_n = settle + 1'b1;
          end
        end
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      o_div_ratio <= DEF_R;
      o_clk_en    <= 1'b0;
      o_busy      <= 1'b0;
      o_cfg_err   <= 1'b0;
      pending     <= DEF_R;
      settle      <= '0;
    end else begin
      state       <= nxt;
      o_div_ratio <= ratio_n;
      o_clk_en    <= en_n;
      o_busy      <= busy_n;
      o_cfg_err   <= err_n;
      pending     <= pend_n;
      settle      <= settle_n;
    end
  end

`ifdef CLK_DIV_RATIO_CTRL_STATS_EN
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_switch_cnt <= '0;
      o_err_sticky <= 1'b0;
    end else begin
      if (state == GATE && nxt == RUN &&
          o_switch_cnt != 8'hff) begin
        o_switch_cnt <= o_switch_cnt + 1'b1;
      end
      if (o_cfg_err) begin
        o_err_sticky <= 1'b1;
      end
    end
  end
`endif

endmodule
